// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared processor definitions: control rod layout,
// default widths and the hazard unit's action codes.
package pipeline_hazard_ctrl_pkg;

  localparam int DEF_RAW = 5;
  localparam int DEF_CW  = 10;
  localparam int DEF_SCW = 16;

  localparam int C_ALU_LSB = 0;
  localparam int C_BRANCH  = 3;
  localparam int C_LOAD    = 4;
  localparam int C_MEMWR   = 5;
  localparam int C_REGWR   = 6;
  localparam int C_JMP     = 7;
  localparam int C_RD_B    = 8;
  localparam int C_RD_A    = 9;

  localparam logic [3:0] OP_NOP = 4'b1000;

  typedef enum logic [1:0] {
    ACT_RUN,
    ACT_STALL,
    ACT_JMP,
    ACT_BR
  } act_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_slot.sv
// One in-flight pipeline slot (EX or MEM) with
// destination compare against both ID sources.
module hazard_slot #(
  parameter int RAW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ld_valid,
  input  logic           ld_regwrite,
  input  logic [RAW-1:0] ld_rd,
  input  logic [RAW-1:0] rs_a,
  input  logic [RAW-1:0] rs_b,
  output logic           valid,
  output logic           regwrite,
  output logic [RAW-1:0] rd,
  output logic           hit_a,
  output logic           hit_b
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      regwrite <= 1'b0;
      rd       <= '0;
    end else begin
      valid    <= ld_valid;
      regwrite <= ld_regwrite;
      rd       <= ld_rd;
    end
  end

  assign hit_a = valid & regwrite & (rd == rs_a);
  assign hit_b = valid & regwrite & (rd == rs_b);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// RAW interlock and control-flow flush for the
// ID stage, with a saturating stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int RAW = DEF_RAW,
  parameter int CW  = DEF_CW,
  parameter int SCW = DEF_SCW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           id_valid,
  input  logic [CW-1:0]  id_ctrl,
  input  logic [3:0]     id_rs_a,
  input  logic [RAW-1:0] id_rs_b,
  input  logic [RAW-1:0] id_rd,
  input  logic           ex_branch_taken,
  output logic           pc_en,
  output logic           ifid_en,
  output logic           ifid_flush,
  output logic           idex_bubble,
  output logic [SCW-1:0] stall_count
);

  logic [RAW-1:0] rs_a;
  logic           ex_valid, ex_rw;
  logic [RAW-1:0] ex_rd;
  logic           mem_valid, mem_rw;
  logic [RAW-1:0] mem_rd;
  logic           ex_hit_a, ex_hit_b;
  logic           mem_hit_a, mem_hit_b;
  logic           hazard, jmp, issue;
  logic           unused_ctrl;
  act_e           act;

  assign rs_a = RAW'(id_rs_a);
  assign unused_ctrl = ^{id_ctrl, mem_valid, mem_rw, mem_rd};

  hazard_slot #(.RAW(RAW)) u_ex (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_valid    (issue),
    .ld_regwrite (issue & id_ctrl[C_REGWR]),
    .ld_rd       (issue ? id_rd : '0),
    .rs_a        (rs_a),
    .rs_b        (id_rs_b),
    .valid       (ex_valid),
    .regwrite    (ex_rw),
    .rd          (ex_rd),
    .hit_a       (ex_hit_a),
    .hit_b       (ex_hit_b)
  );

  hazard_slot #(.RAW(RAW)) u_mem (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_valid    (ex_valid),
    .ld_regwrite (ex_rw),
    .ld_rd       (ex_rd),
    .rs_a        (rs_a),
    .rs_b        (id_rs_b),
    .valid       (mem_valid),
    .regwrite    (mem_rw),
    .rd          (mem_rd),
    .hit_a       (mem_hit_a),
    .hit_b       (mem_hit_b)
  );

  assign hazard = id_valid &
    ((id_ctrl[C_RD_A] & (ex_hit_a | mem_hit_a)) |
     (id_ctrl[C_RD_B] & (ex_hit_b | mem_hit_b)));
  assign jmp = id_valid & id_ctrl[C_JMP];

  always_comb begin
    act = ACT_RUN;
    if (ex_branch_taken) act = ACT_BR;
    else if (jmp)        act = ACT_JMP;
    else if (hazard)     act = ACT_STALL;
  end

  assign issue = id_valid &
    ((act == ACT_RUN) | (act == ACT_JMP));

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    unique case (act)
      ACT_BR: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      ACT_JMP: ifid_flush = 1'b1;
      ACT_STALL: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end
      ACT_RUN: ;
    endcase
    // hold fetch and squash ID/EX while in reset
    if (!rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (hazard & ~ex_branch_taken & ~&stall_count)
      stall_count <= stall_count + SCW'(1);
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Random + directed bench for pipeline_hazard_ctrl
// against a recent-issue history model.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  typedef struct {
    logic       v;
    logic [9:0] c;
    logic [3:0] ra;
    logic [4:0] rb;
    logic [4:0] rd;
  } ins_t;

  typedef struct {
    bit       v;
    bit       w;
    bit [4:0] rd;
  } iss_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [9:0] id_ctrl = '0;
  logic [3:0] id_rs_a = '0;
  logic [4:0] id_rs_b = '0;
  logic [4:0] id_rd = '0;
  logic       ex_branch_taken = 1'b0;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble;
  logic [15:0] stall_count;
  logic       pc_en4, ifid_en4, ifid_flush4, idex_bubble4;
  logic [3:0] stall_count4;

  int nvec = 0;
  int nbad = 0;

  iss_t hist[1:2];
  int   nstall;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_ctrl(id_ctrl), .id_rs_a(id_rs_a),
    .id_rs_b(id_rs_b), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .stall_count(stall_count)
  );

  pipeline_hazard_ctrl #(.SCW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_ctrl(id_ctrl), .id_rs_a(id_rs_a),
    .id_rs_b(id_rs_b), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en4), .ifid_en(ifid_en4),
    .ifid_flush(ifid_flush4), .idex_bubble(idex_bubble4),
    .stall_count(stall_count4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic bit writes(input logic [4:0] r);
    for (int k = 1; k <= 2; k++)
      if (hist[k].v && hist[k].w && hist[k].rd == r)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  function automatic ins_t mk(input int kind,
                              input int ra, input int rb,
                              input int rd);
    ins_t i;
    i.v  = 1'b1;
    i.c  = '0;
    i.ra = 4'(ra);
    i.rb = 5'(rb);
    i.rd = 5'(rd);
    case (kind)
      0: begin
        i.c[2:0] = 3'($urandom_range(0, 7));
        i.c[C_REGWR] = 1'b1;
        i.c[C_RD_A] = 1'b1;
        i.c[C_RD_B] = 1'b1;
      end
      1: begin
        i.c[C_LOAD] = 1'b1;
        i.c[C_REGWR] = 1'b1;
        i.c[C_RD_A] = 1'b1;
      end
      2: begin
        i.c[C_MEMWR] = 1'b1;
        i.c[C_RD_A] = 1'b1;
        i.c[C_RD_B] = 1'b1;
      end
      3: begin
        i.c[C_BRANCH] = 1'b1;
        i.c[C_RD_A] = 1'b1;
        i.c[C_RD_B] = 1'b1;
      end
      4: i.c[C_JMP] = 1'b1;
      default: ;
    endcase
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    i = mk($urandom_range(0, 5), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) i.v = 1'b0;
    return i;
  endfunction

  task automatic model_reset();
    for (int k = 1; k <= 2; k++) hist[k] = '{0, 0, 0};
    nstall = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_cnt", 32'(stall_count), 0);
    chk("rst_cnt4", 32'(stall_count4), 0);
    chk("rst_pc", 32'(pc_en), 0);
    chk("rst_ifid", 32'(ifid_en), 0);
    chk("rst_flush", 32'(ifid_flush), 1);
    chk("rst_bub", 32'(idex_bubble), 1);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic cyc(input ins_t i, input logic br,
                     output bit flush, output bit hold);
    bit hz, jmp, iss;
    bit e_pc, e_en, e_fl, e_bb;
    id_valid = i.v;
    id_ctrl = i.c;
    id_rs_a = i.ra;
    id_rs_b = i.rb;
    id_rd = i.rd;
    ex_branch_taken = br;
    hz = i.v && ((i.c[C_RD_A] && writes(5'(i.ra))) ||
                 (i.c[C_RD_B] && writes(i.rb)));
    jmp = i.v && i.c[C_JMP];
    if (br) begin
      e_pc = 1; e_en = 1; e_fl = 1; e_bb = 1;
    end else if (jmp) begin
      e_pc = 1; e_en = 1; e_fl = 1; e_bb = 0;
    end else if (hz) begin
      e_pc = 0; e_en = 0; e_fl = 0; e_bb = 1;
    end else begin
      e_pc = 1; e_en = 1; e_fl = 0; e_bb = 0;
    end
    @(negedge clk);
    chk("pc_en", 32'(pc_en), 32'(e_pc));
    chk("ifid_en", 32'(ifid_en), 32'(e_en));
    chk("ifid_flush", 32'(ifid_flush), 32'(e_fl));
    chk("idex_bubble", 32'(idex_bubble), 32'(e_bb));
    chk("bubble4", 32'(idex_bubble4), 32'(e_bb));
    chk("stall_cnt", 32'(stall_count), 32'(sat(nstall, 65535)));
    chk("stall_cnt4", 32'(stall_count4), 32'(sat(nstall, 15)));
    @(posedge clk);
    if (hz && !br) nstall++;
    iss = i.v && !br && (jmp || !hz);
    hist[2] = hist[1];
    hist[1] = '{iss, iss && i.c[C_REGWR], i.rd};
    #1;
    flush = e_fl;
    hold = !e_en;
  endtask

  ins_t nop, cur;
  bit fl, hd;

  initial begin
    nop = mk(5, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // back-to-back dependency: two stalls
    cyc(mk(0, 0, 0, 3), 0, fl, hd);
    repeat (3) cyc(mk(1, 3, 0, 1), 0, fl, hd);
    chk("b2b_cnt", 32'(stall_count), 2);

    // distance 2: one stall
    do_reset();
    cyc(mk(0, 0, 0, 3), 0, fl, hd);
    cyc(nop, 0, fl, hd);
    repeat (2) cyc(mk(3, 0, 3, 0), 0, fl, hd);
    chk("d2_cnt", 32'(stall_count), 1);

    // store never forwards a hazard
    do_reset();
    cyc(mk(2, 0, 0, 4), 0, fl, hd);
    cyc(mk(1, 4, 0, 2), 0, fl, hd);
    chk("st_pc", 32'(stall_count), 0);

    // branch wins over stall
    do_reset();
    cyc(mk(0, 0, 0, 3), 0, fl, hd);
    cyc(mk(1, 3, 0, 1), 1, fl, hd);
    chk("br_cnt", 32'(stall_count), 0);

    // jump flushes, issues without regwrite
    do_reset();
    cyc(mk(4, 0, 0, 5), 0, fl, hd);
    chk("jmp_fl", 32'(fl), 1);
    cyc(mk(1, 5, 0, 1), 0, fl, hd);
    chk("jmp_nohz", 32'(stall_count), 0);

    // saturation with chained self-dependent writers
    do_reset();
    repeat (36) cyc(mk(0, 1, 1, 1), 0, fl, hd);
    chk("sat4", 32'(stall_count4), 15);
    chk("sat16", 32'(stall_count), 24);
    cyc(mk(0, 1, 1, 1), 0, fl, hd);
    do_reset();
    cyc(mk(0, 1, 1, 1), 0, fl, hd);
    chk("rst_nostall", 32'(hd), 0);

    // random program with fetch-side model
    do_reset();
    cur = rnd_ins();
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) begin
        do_reset();
        cur = rnd_ins();
      end
      cyc(cur, ($urandom_range(0, 9) == 0), fl, hd);
      if (fl) cur = nop;
      else if (!hd) cur = rnd_ins();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: RAW, default 5, register address width.
REQ-002 Parameter: CW, default 10, control rod width.
REQ-003 Parameter: SCW, default 16, stall counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 id_valid  input  1  instruction present in ID stage.
REQ-007 id_ctrl  input  CW  control rod of ID instruction: [2:0] ALU op, [3] IsBranch, [4] IsLoad, [5] IsMemWrite, [6] IsRegWrite, [7] JMP, [8] reads src B, [9] reads src A.
REQ-008 id_rs_a  input  4  src A (instruction bits 5-8), zero-extended to RAW internally.
REQ-009 id_rs_b  input  RAW  src B (instruction bits 9-13).
REQ-010 id_rd  input  RAW  destination register of ID instruction.
REQ-011 ex_branch_taken  input  1  BEQ in EX resolved taken this cycle.
REQ-012 pc_en  output  1  PC update enable.
REQ-013 ifid_en  output  1  IF/ID register load enable.
REQ-014 ifid_flush  output  1  IF/ID cleared to NOP (1000) next edge.
REQ-015 idex_bubble  output  1  ID/EX loaded with all-zero control rod next edge.
REQ-016 stall_count  output  SCW  saturating count of stall cycles.

Function
REQ-017 Block SHALL keep two in-flight slots, EX and MEM, each {valid, regwrite, rd}; WB writes through the register file and is not tracked.
REQ-018 Each edge: MEM <= EX; EX <= {1, id_ctrl[6], id_rd} if issue, else {0,0,0}.
REQ-019 issue = id_valid & ~stall & ~ex_branch_taken.
REQ-020 hit(src) = any slot with valid & regwrite & rd == src.
REQ-021 stall = id_valid & ((id_ctrl[9] & hit(rs_a)) | (id_ctrl[8] & hit(rs_b))), combinational.
REQ-022 On stall (no flush): pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0.
REQ-023 On ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_en=1, ifid_en=1; stall ignored and not counted that cycle.
REQ-024 On id_valid & id_ctrl[7] (JMP) without ex_branch_taken: ifid_flush=1, pc_en=1, ifid_en=1, idex_bubble=0 (JMP issues).
REQ-025 Priority: ex_branch_taken > JMP > stall > normal.
REQ-026 Normal: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
REQ-027 RAW hazard SHALL hold ID at most 2 cycles (writer drains EX then MEM); back-to-back dependency yields exactly 2 stall cycles, dependency at distance 2 yields 1, distance 3 yields 0.
REQ-028 stall_count increments by 1 per cycle with stall asserted and ex_branch_taken low; saturates at all-ones, no wrap.
REQ-029 id_valid=0: no stall, no flush, EX loaded with empty slot.
REQ-030 NOP, BEQ, ST (regwrite=0) SHALL never create a hit.

Reset
REQ-031 rst_n low SHALL immediately clear both slots and stall_count to 0.
REQ-032 During reset outputs: pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1.
REQ-033 Reset release mid-stall SHALL resume with empty slots, i.e. no residual stall.

Structure
REQ-034 Control rod bit indices, RAW, and NOP opcode 1000 SHALL live in the shared processor package.
REQ-035 Sub-module hazard_slot (one EX/MEM slot register + rd compare) SHALL be instantiated twice.

Verification
REQ-036 ADD r3 (rd=3) then ADD reading rs_a=3 -> stall 2 cycles, idex_bubble=1 twice, stall_count=2.
REQ-037 ADD r3, NOP, ADD rs_b=3 (ctrl[8]=1) -> exactly 1 stall cycle.
REQ-038 ST (ctrl[6]=0) to rd=4, then reader rs_a=4 -> no stall.
REQ-039 Stall active, ex_branch_taken=1 same cycle -> ifid_flush=1, idex_bubble=1, pc_en=1, stall_count unchanged.
REQ-040 JMP in ID -> ifid_flush=1 one cycle, pc_en=1, EX slot valid with regwrite=0.
REQ-041 Force SCW=4, hold hazard 20 cycles via repeated writers -> stall_count stays 15; assert rst_n=0 mid-stall -> count 0, slots empty asynchronously.
